// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter
//   Packet-aware round-robin arbiter. Merges NUM_PORTS AXI-Stream sources onto
//   one registered master stream. A grant is held from the first beat until the
//   tlast beat is accepted, so packets from different sources never interleave.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous reset, active-high
//   s_tdata   per-port data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid  per-port valid
//   s_tready  per-port ready (only the granted port can see 1)
//   s_tlast   per-port end-of-packet
//   m_tdata   merged data (registered)
//   m_tvalid  merged valid (registered)
//   m_tready  downstream ready
//   m_tlast   merged end-of-packet (registered)
//   grant_id  port currently granted, or last granted while idle
//   busy      1 while a packet is being streamed
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no grant; pick next requester in rotation after last_grant
// STREAM | grant_id owns the output until its tlast beat is accepted

module axis_rr_arbiter #(
   parameter int  DATA_WIDTH = 8,
   parameter int  NUM_PORTS  = 4,
   localparam int IDW        = $clog2(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_PORTS-1:0]            s_tvalid,
   output logic [NUM_PORTS-1:0]            s_tready,
   input  logic [NUM_PORTS-1:0]            s_tlast,
   output logic [DATA_WIDTH-1:0]           m_tdata,
   output logic                            m_tvalid,
   input  logic                            m_tready,
   output logic                            m_tlast,
   output logic [IDW-1:0]                  grant_id,
   output logic                            busy
);

   localparam int SW = IDW + 1;

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t                state;
   logic [IDW-1:0]        last_grant;

   logic                  pick_valid;
   logic [IDW-1:0]        pick_idx;
   logic [SW-1:0]         arb_sum;

   logic [DATA_WIDTH-1:0] g_data;
   logic                  g_valid;
   logic                  g_last;
   logic                  g_ready;
   logic                  accept;

   // Rotating priority: walk candidates from farthest to nearest so the
   // nearest port after last_grant overwrites the pick and wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      arb_sum    = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         arb_sum = {1'b0, last_grant} + SW'(k);
         if (arb_sum >= SW'(NUM_PORTS)) begin
            arb_sum = arb_sum - SW'(NUM_PORTS);
         end
         if (s_tvalid[arb_sum[IDW-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = arb_sum[IDW-1:0];
         end
      end
   end

   // Select the granted port with constant slices only, so X on idle ports
   // never reaches the output register.
   always_comb begin
      g_data  = '0;
      g_valid = 1'b0;
      g_last  = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_id == IDW'(i)) begin
            g_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            g_valid = s_tvalid[i];
            g_last  = s_tlast[i];
         end
      end
   end

   // Output stage can take a new beat when empty or draining this cycle.
   assign g_ready = m_tready || !m_tvalid;
   assign accept  = (state == STREAM) && g_valid && g_ready;

   always_comb begin
      s_tready = '0;
      if (state == STREAM) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_id == IDW'(i)) begin
               s_tready[i] = g_ready;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         grant_id   <= '0;
         last_grant <= IDW'(NUM_PORTS - 1);
         m_tdata    <= '0;
         m_tvalid   <= 1'b0;
         m_tlast    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant_id   <= pick_idx;
                  last_grant <= pick_idx;
                  state      <= STREAM;
                  busy       <= 1'b1;
               end
            end
            STREAM: begin
               if (accept && g_last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase

         if (accept) begin
            m_tdata  <= g_data;
            m_tlast  <= g_last;
            m_tvalid <= 1'b1;
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
module tb_axis_rr_arbiter;

   localparam int DW = 8;
   localparam int NP = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [NP*DW-1:0] s_tdata;
   logic [NP-1:0]    s_tvalid;
   logic [NP-1:0]    s_tready;
   logic [NP-1:0]    s_tlast;
   logic [DW-1:0]    m_tdata;
   logic             m_tvalid;
   logic             m_tready;
   logic             m_tlast;
   logic [1:0]       grant_id;
   logic             busy;

   always #5 clk = ~clk;

   axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
      .clk      (clk),
      .reset    (reset),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .s_tlast  (s_tlast),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
      .m_tlast  (m_tlast),
      .grant_id (grant_id),
      .busy     (busy)
   );

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   typedef struct {
      logic [NP-1:0] mask;
      int            n;
      int            ord[4];
   } vec_t;

   beat_t         port_q[NP][$];
   logic [8:0]    exp_q[$];
   int            out_cyc[$];
   logic [NP-1:0] port_en = '1;
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            bad02 = 0;
   bit            chk02 = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_beat(input int p, input logic [7:0] d, input logic l);
      port_q[p].push_back({l, d});
   endtask

   task automatic expect_beat(input logic [7:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   function automatic bit ports_pending();
      for (int i = 0; i < NP; i++) begin
         if (port_q[i].size() > 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic wait_drain(input string name);
      int c;
      c = 0;
      while ((exp_q.size() > 0 || ports_pending()) && c < 200) begin
         tick();
         c++;
      end
      check({name, " drain"}, exp_q.size(), 0);
      exp_q.delete();
      tick();
      tick();
   endtask

   // Source driver and output monitor. Handshakes are sampled at negedge,
   // sources advance just after the posedge that completed the transfer.
   initial begin
      logic [NP-1:0] hs;
      beat_t         b;
      logic [8:0]    e;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tlast  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         hs = s_tvalid & s_tready;
         if (chk02 && (s_tready[0] || s_tready[2])) bad02++;
         if (!reset && m_tvalid && m_tready) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got %0h expected none", {m_tlast, m_tdata});
            end else begin
               e = exp_q.pop_front();
               check("out_beat", {23'b0, m_tlast, m_tdata}, {23'b0, e});
            end
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < NP; i++) begin
            if (!reset && hs[i] && port_q[i].size() > 0) b = port_q[i].pop_front();
            if (port_en[i] && port_q[i].size() > 0) begin
               b = port_q[i][0];
               s_tvalid[i]          = 1'b1;
               s_tdata[i*DW +: DW]  = b.data;
               s_tlast[i]           = b.last;
            end else begin
               s_tvalid[i]          = 1'b0;
               s_tdata[i*DW +: DW]  = 'x;
               s_tlast[i]           = 1'bx;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[7];
      int   base;
      int   c;

      tbl[0] = '{4'b1111, 4, '{1, 2, 3, 0}};
      tbl[1] = '{4'b0101, 2, '{2, 0, 0, 0}};
      tbl[2] = '{4'b1000, 1, '{3, 0, 0, 0}};
      tbl[3] = '{4'b1001, 2, '{0, 3, 0, 0}};
      tbl[4] = '{4'b0110, 2, '{1, 2, 0, 0}};
      tbl[5] = '{4'b1011, 3, '{3, 0, 1, 0}};
      tbl[6] = '{4'b0010, 1, '{1, 0, 0, 0}};

      m_tready = 1'b1;
      reset    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst m_tvalid", m_tvalid, 0);
      check("rst m_tdata", m_tdata, 0);
      check("rst m_tlast", m_tlast, 0);
      check("rst s_tready", s_tready, 0);
      check("rst busy", busy, 0);
      check("rst grant_id", grant_id, 0);
      tick();
      reset = 1'b0;
      tick();

      // all four ports, one-beat packets at once
      for (int p = 0; p < NP; p++) push_beat(p, 8'(8'hA0 + p), 1'b1);
      for (int p = 0; p < NP; p++) expect_beat(8'(8'hA0 + p), 1'b1);
      base = out_cyc.size();
      wait_drain("t2");
      for (int k = 1; k < 4; k++) check("t2 gap", out_cyc[base+k] - out_cyc[base+k-1], 2);
      check("t2 grant_id", grant_id, 3);

      // port0 three-beat packet at full rate
      push_beat(0, 8'h11, 1'b0);
      push_beat(0, 8'h22, 1'b0);
      push_beat(0, 8'h33, 1'b1);
      expect_beat(8'h11, 1'b0);
      expect_beat(8'h22, 1'b0);
      expect_beat(8'h33, 1'b1);
      base = out_cyc.size();
      wait_drain("t1");
      check("t1 spacing a", out_cyc[base+1] - out_cyc[base], 1);
      check("t1 spacing b", out_cyc[base+2] - out_cyc[base+1], 1);
      check("t1 grant_id", grant_id, 0);
      check("t1 busy idle", busy, 0);

      // rotation table
      for (int r = 0; r < 7; r++) begin
         for (int p = 0; p < NP; p++) begin
            if (tbl[r].mask[p]) push_beat(p, 8'(8'h40 + 16*r + p), 1'b1);
         end
         for (int j = 0; j < tbl[r].n; j++) expect_beat(8'(8'h40 + 16*r + tbl[r].ord[j]), 1'b1);
         wait_drain("tbl");
         check("tbl grant_id", grant_id, tbl[r].ord[tbl[r].n-1]);
      end

      // port0 arrives while port2 is mid-packet
      for (int k = 0; k < 4; k++) push_beat(2, 8'(8'h30 + k), k == 3);
      for (int k = 0; k < 4; k++) expect_beat(8'(8'h30 + k), k == 3);
      c = 0;
      while (port_q[2].size() > 2 && c < 50) begin tick(); c++; end
      check("t3 busy", busy, 1);
      push_beat(0, 8'h50, 1'b0);
      push_beat(0, 8'h51, 1'b1);
      expect_beat(8'h50, 1'b0);
      expect_beat(8'h51, 1'b1);
      c = 0;
      while (port_q[2].size() > 0 && c < 40) begin
         @(negedge clk);
         check("t3 s_tready0 held", s_tready[0], 0);
         c++;
      end
      wait_drain("t3");
      check("t3 grant_id", grant_id, 0);

      // backpressure, then granted source pauses mid-packet
      for (int k = 0; k < 6; k++) push_beat(1, 8'(8'h60 + k), k == 5);
      for (int k = 0; k < 6; k++) expect_beat(8'(8'h60 + k), k == 5);
      base = out_cyc.size();
      c = 0;
      while (out_cyc.size() < base + 1 && c < 50) begin tick(); c++; end
      m_tready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t4 hold valid", m_tvalid, 1);
         check("t4 hold data", m_tdata, 8'h61);
         check("t4 s_tready1", s_tready[1], 0);
      end
      tick();
      m_tready = 1'b1;
      c = 0;
      while (port_q[1].size() > 2 && c < 50) begin tick(); c++; end
      port_en[1] = 1'b0;
      push_beat(2, 8'h70, 1'b1);
      expect_beat(8'h70, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("t4 port2 blocked", s_tready[2], 0);
      end
      tick();
      port_en[1] = 1'b1;
      wait_drain("t4");
      check("t4 grant_id", grant_id, 2);

      // reset during port3's second beat
      push_beat(3, 8'hD0, 1'b0);
      push_beat(3, 8'hD1, 1'b0);
      push_beat(3, 8'hD2, 1'b1);
      expect_beat(8'hD0, 1'b0);
      c = 0;
      while (port_q[3].size() > 2 && c < 50) begin tick(); c++; end
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("t5 m_tvalid", m_tvalid, 0);
      check("t5 m_tdata", m_tdata, 0);
      check("t5 busy", busy, 0);
      check("t5 s_tready", s_tready, 0);
      check("t5 first beat out", exp_q.size(), 0);
      port_q[3].delete();
      tick();
      tick();
      check("t5 grant_id", grant_id, 0);
      reset = 1'b0;
      tick();
      push_beat(0, 8'hE0, 1'b1);
      push_beat(3, 8'hE3, 1'b1);
      expect_beat(8'hE0, 1'b1);
      expect_beat(8'hE3, 1'b1);
      wait_drain("t5");
      check("t5 grant_id after", grant_id, 3);

      // ports 1 and 3 streaming two-beat packets back to back
      chk02 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push_beat(1, 8'(8'h80 + 2*k), 1'b0);
         push_beat(1, 8'(8'h81 + 2*k), 1'b1);
         push_beat(3, 8'(8'h90 + 2*k), 1'b0);
         push_beat(3, 8'(8'h91 + 2*k), 1'b1);
      end
      for (int k = 0; k < 4; k++) begin
         expect_beat(8'(8'h80 + 2*k), 1'b0);
         expect_beat(8'(8'h81 + 2*k), 1'b1);
         expect_beat(8'(8'h90 + 2*k), 1'b0);
         expect_beat(8'(8'h91 + 2*k), 1'b1);
      end
      wait_drain("t6");
      chk02 = 1'b0;
      check("t6 ports0/2 never ready", bad02, 0);
      check("t6 grant_id", grant_id, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
